// File: rtl/nx_arb_pkg.sv
// rtl/nx_arb_pkg.sv - shared types and width helpers for the buffered stream arbiter
package nx_arb_pkg;

    typedef enum logic {
        ARB_ROUND_ROBIN    = 1'b0,
        ARB_FIXED_PRIORITY = 1'b1
    } arb_mode_t;

    // Occupancy needs one extra bit so that a full FIFO is distinct from an empty one.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/nx_stream_fifo.sv
// rtl/nx_stream_fifo.sv - per-channel message buffer with registered occupancy count
module nx_stream_fifo
    import nx_arb_pkg::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [STREAM_WIDTH-1:0]              data,
    output logic                                 full,
    input  logic                                 pop,
    output logic [STREAM_WIDTH-1:0]              head,
    output logic                                 empty,
    output logic [level_width(FIFO_DEPTH)-1:0]   level
);

    localparam int PW = index_width(FIFO_DEPTH);
    localparam int LW = level_width(FIFO_DEPTH);

    logic [STREAM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [LW-1:0]           count;
    logic                    do_push;
    logic                    do_pop;

    // Full/empty come from the registered count: no push-through, no same-entry bypass.
    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nx_stream_arbiter_buffered.sv
// rtl/nx_stream_arbiter_buffered.sv - merges buffered inbound streams into one tagged outbound stream
module nx_stream_arbiter_buffered
    import nx_arb_pkg::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int CHANNELS     = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int ARB_MODE     = 0
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [CHANNELS*STREAM_WIDTH-1:0]              ib_data_i,
    input  logic [CHANNELS-1:0]                           ib_valid_i,
    output logic [CHANNELS-1:0]                           ib_ready_o,
    output logic [STREAM_WIDTH-1:0]                       arb_data_o,
    output logic [$clog2(CHANNELS)-1:0]                   arb_dir_o,
    output logic                                          arb_valid_o,
    input  logic                                          arb_ready_i,
    output logic [CHANNELS*($clog2(FIFO_DEPTH)+1)-1:0]    level_o,
    output logic                                          idle_o
);

    localparam int DW = $clog2(CHANNELS);
    localparam int LW = level_width(FIFO_DEPTH);
    localparam bit FIXED = (ARB_MODE == int'(ARB_FIXED_PRIORITY));

    logic [CHANNELS-1:0]     full;
    logic [CHANNELS-1:0]     empty;
    logic [CHANNELS-1:0]     push;
    logic [CHANNELS-1:0]     pop;
    logic [STREAM_WIDTH-1:0] head [CHANNELS];
    logic [LW-1:0]           level [CHANNELS];

    logic                    load_en;
    logic                    found;
    logic [DW-1:0]           grant;
    logic [DW-1:0]           last_grant;

    assign load_en = !arb_valid_o || arb_ready_i;
    assign idle_o  = (&empty) && !arb_valid_o;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign ib_ready_o[g] = !rst_i && !full[g];
        assign push[g]       = ib_valid_i[g] && ib_ready_o[g];
        assign pop[g]        = load_en && found && (grant == DW'(g));
        assign level_o[g*LW +: LW] = level[g];

        nx_stream_fifo #(
            .STREAM_WIDTH (STREAM_WIDTH),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (push[g]),
            .data  (ib_data_i[g*STREAM_WIDTH +: STREAM_WIDTH]),
            .full  (full[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .empty (empty[g]),
            .level (level[g])
        );
    end

    // Round-robin searches upward from the slot after the last grant; fixed priority from 0.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = FIXED ? i : (int'(last_grant) + 1 + i) % CHANNELS;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arb_valid_o <= 1'b0;
            arb_data_o  <= '0;
            arb_dir_o   <= '0;
            last_grant  <= DW'(CHANNELS - 1);
        end else if (load_en) begin
            arb_valid_o <= found;
            if (found) begin
                arb_data_o <= head[grant];
                arb_dir_o  <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_nx_stream_arbiter_buffered.sv
// tb/tb_nx_stream_arbiter_buffered.sv - directed self-checking bench for nx_stream_arbiter_buffered
module tb_nx_stream_arbiter_buffered;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] ib_data;
    logic [N-1:0]   ib_valid;
    logic           arb_ready;

    logic [N-1:0]    rr_ready, fp_ready;
    logic [W-1:0]    rr_data, fp_data;
    logic [1:0]      rr_dir, fp_dir;
    logic            rr_valid, fp_valid;
    logic [N*LW-1:0] rr_level, fp_level;
    logic            rr_idle, fp_idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx_stream_arbiter_buffered #(.STREAM_WIDTH(W), .CHANNELS(N), .FIFO_DEPTH(D), .ARB_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .ib_data_i(ib_data), .ib_valid_i(ib_valid), .ib_ready_o(rr_ready),
        .arb_data_o(rr_data), .arb_dir_o(rr_dir), .arb_valid_o(rr_valid), .arb_ready_i(arb_ready),
        .level_o(rr_level), .idle_o(rr_idle)
    );

    nx_stream_arbiter_buffered #(.STREAM_WIDTH(W), .CHANNELS(N), .FIFO_DEPTH(D), .ARB_MODE(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .ib_data_i(ib_data), .ib_valid_i(ib_valid), .ib_ready_o(fp_ready),
        .arb_data_o(fp_data), .arb_dir_o(fp_dir), .arb_valid_o(fp_valid), .arb_ready_i(arb_ready),
        .level_o(fp_level), .idle_o(fp_idle)
    );

    function automatic logic [LW-1:0] lvl(input logic [N*LW-1:0] l, input int ch);
        return l[ch*LW +: LW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ib_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle;
        ib_valid = '0;
        arb_ready = 1'b1;
        for (int i = 0; i < 40 && !(rr_idle && fp_idle); i++) tick();
        #1;
        checks++;
        if ((rr_idle && fp_idle) !== 1'b1) begin
            errors++; $display("FAIL wait_idle: got rr=%0b fp=%0b expected 1", rr_idle, fp_idle);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ib_valid = '0; ib_data = '0; arb_ready = 1'b1;
        tick(); tick(); #1;
        checks++;
        if (rr_ready !== 4'h0) begin errors++; $display("FAIL reset_ready_gate: got %0h expected 0", rr_ready); end
        rst = 1'b0; #1;
        checks++;
        if (rr_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b expected 1", rr_idle); end
        checks++;
        if (rr_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %0h expected f", rr_ready); end
        checks++;
        if (rr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rr_valid); end
        checks++;
        if (rr_level !== 8'h00) begin errors++; $display("FAIL reset_level: got %0h expected 0", rr_level); end
        checks++;
        if ({rr_data, rr_dir} !== 34'h0) begin errors++; $display("FAIL reset_data_dir: got %0h/%0h expected 0/0", rr_data, rr_dir); end
        checks++;
        if (fp_idle !== 1'b1) begin errors++; $display("FAIL reset_fp_idle: got %0b expected 1", fp_idle); end
    endtask

    task automatic test_single_push;
        ib_data[2*W +: W] = 32'hA5A5_0001;
        ib_valid = 4'b0100; #1;
        checks++;
        if (rr_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", rr_ready[2]); end
        tick();
        ib_valid = '0; #1;
        checks++;
        if (rr_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %0b expected 0", rr_valid); end
        checks++;
        if (lvl(rr_level, 2) !== 2'd1) begin errors++; $display("FAIL single_c1_level: got %0d expected 1", lvl(rr_level, 2)); end
        tick(); #1;
        checks++;
        if (rr_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid: got %0b expected 1", rr_valid); end
        checks++;
        if (rr_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_c2_data: got %0h expected a5a50001", rr_data); end
        checks++;
        if (rr_dir !== 2'd2) begin errors++; $display("FAIL single_c2_dir: got %0d expected 2", rr_dir); end
        tick(); #1;
        checks++;
        if ({rr_valid, rr_idle} !== 2'b01) begin errors++; $display("FAIL single_c3_drained: got valid=%0b idle=%0b expected 0/1", rr_valid, rr_idle); end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int n = 0; n < N; n++) ib_data[n*W +: W] = 32'h100 + n;
        ib_valid = 4'hF; arb_ready = 1'b1;
        tick(); #1;
        checks++;
        if (rr_valid !== 1'b0) begin errors++; $display("FAIL rr_c1_valid: got %0b expected 0", rr_valid); end
        tick();
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if ({rr_valid, rr_dir} !== {1'b1, 2'(k % 4)}) begin
                errors++; $display("FAIL rr_grant[%0d]: got valid=%0b dir=%0d expected 1/%0d", k, rr_valid, rr_dir, k % 4);
            end
            checks++;
            if (rr_data !== 32'h100 + 32'(k % 4)) begin
                errors++; $display("FAIL rr_data[%0d]: got %0h expected %0h", k, rr_data, 32'h100 + 32'(k % 4));
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_fixed_priority;
        do_reset();
        ib_data[0 +: W] = 32'h200; ib_data[3*W +: W] = 32'h203;
        ib_valid = 4'b1001; arb_ready = 1'b1;
        tick(); tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ({fp_valid, fp_dir, fp_data} !== {1'b1, 2'd0, 32'h200}) begin
                errors++; $display("FAIL fp_grant[%0d]: got valid=%0b dir=%0d data=%0h expected 1/0/200", k, fp_valid, fp_dir, fp_data);
            end
            tick();
        end
        #1;
        checks++;
        if (lvl(fp_level, 3) !== 2'd2) begin errors++; $display("FAIL fp_ch3_level: got %0d expected 2", lvl(fp_level, 3)); end
        checks++;
        if (fp_ready[3] !== 1'b0) begin errors++; $display("FAIL fp_ch3_ready: got %0b expected 0", fp_ready[3]); end
        ib_valid = 4'b1000;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({fp_valid, fp_dir, fp_data} !== {1'b1, 2'd3, 32'h203}) begin
                errors++; $display("FAIL fp_drain[%0d]: got valid=%0b dir=%0d data=%0h expected 1/3/203", k, fp_valid, fp_dir, fp_data);
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_back_pressure;
        int  sent = 0;
        int  recv = 0;
        logic pushed;
        arb_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            ib_valid = (sent < 3) ? 4'b0010 : 4'b0000;
            ib_data[W +: W] = 32'(sent + 1);
            #1;
            if (cyc >= 2) begin
                checks++;
                if ({rr_valid, rr_data} !== {1'b1, 32'd1}) begin
                    errors++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%0h expected 1/1", cyc, rr_valid, rr_data);
                end
            end
            pushed = ib_valid[1] && rr_ready[1];
            tick();
            if (pushed) sent++;
        end
        #1;
        checks++;
        if ({lvl(rr_level, 1), rr_ready[1]} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL bp_full: got level=%0d ready=%0b expected 2/0", lvl(rr_level, 1), rr_ready[1]);
        end
        checks++;
        if (sent !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", sent); end
        arb_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && recv < 3; cyc++) begin
            #1;
            if (rr_valid) begin
                checks++;
                if (rr_data !== 32'(recv + 1)) begin errors++; $display("FAIL bp_order[%0d]: got %0h expected %0h", recv, rr_data, recv + 1); end
                recv++;
            end
            tick();
        end
        checks++;
        if (recv !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", recv); end
        wait_idle();
    endtask

    task automatic test_wrap;
        int  sent = 0;
        int  recv = 0;
        logic pushed;
        for (int cyc = 0; cyc < 80 && recv < 9; cyc++) begin
            ib_valid = (sent < 9) ? 4'b0001 : 4'b0000;
            ib_data[0 +: W] = 32'h300 + 32'(sent);
            arb_ready = ((cyc / 3) % 2) == 1;
            #1;
            pushed = ib_valid[0] && rr_ready[0];
            if (rr_valid && arb_ready) begin
                checks++;
                if ({rr_dir, rr_data} !== {2'd0, 32'h300 + 32'(recv)}) begin
                    errors++; $display("FAIL wrap_order[%0d]: got dir=%0d data=%0h expected 0/%0h", recv, rr_dir, rr_data, 32'h300 + 32'(recv));
                end
                recv++;
            end
            tick();
            if (pushed) sent++;
        end
        ib_valid = '0; arb_ready = 1'b1; #1;
        checks++;
        if (recv !== 9) begin errors++; $display("FAIL wrap_count: got %0d expected 9", recv); end
        checks++;
        if ({rr_level, rr_idle} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL wrap_level: got level=%0h idle=%0b expected 0/1", rr_level, rr_idle);
        end
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < 3; n++) ib_data[n*W +: W] = 32'h400 + n;
        ib_valid = 4'b0111; arb_ready = 1'b0;
        repeat (4) tick();
        #1;
        checks++;
        if ({rr_valid, lvl(rr_level, 0) != 0, lvl(rr_level, 1) != 0, lvl(rr_level, 2) != 0} !== 4'hF) begin
            errors++; $display("FAIL mid_preload: got valid=%0b level=%0h expected 1/nonzero x3", rr_valid, rr_level);
        end
        rst = 1'b1; ib_valid = '0; #1;
        checks++;
        if (rr_ready !== 4'h0) begin errors++; $display("FAIL mid_ready_gate: got %0h expected 0", rr_ready); end
        tick();
        rst = 1'b0; #1;
        checks++;
        if ({rr_valid, rr_level, rr_idle} !== {1'b0, 8'h00, 1'b1}) begin
            errors++; $display("FAIL mid_after_reset: got valid=%0b level=%0h idle=%0b expected 0/0/1", rr_valid, rr_level, rr_idle);
        end
        arb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            checks++;
            if (rr_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got valid=%0b data=%0h expected 0", k, rr_valid, rr_data); end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_fixed_priority();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/nx_stream_arbiter_buffered.md
Name: nx_stream_arbiter_buffered

Overview:
Parametrised successor to the node's four-way inbound stream arbiter. It merges CHANNELS inbound message streams into one outbound stream. Each channel has its own buffer FIFO, so a stalled downstream decoder does not back-pressure the mesh links immediately. Arbitration is either round-robin or fixed-priority, selected by parameter, and the output carries the index of the source channel (the "direction" in the node).

Parameters:
STREAM_WIDTH, 32, message width in bits
CHANNELS, 4, number of inbound streams; must be at least 2
FIFO_DEPTH, 2, entries per channel FIFO; must be a power of 2 and at least 2
ARB_MODE, 0, 0 selects round-robin, 1 selects fixed priority (channel 0 highest)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
ib_data_i  in  CHANNELS*STREAM_WIDTH  inbound data, packed; channel n occupies bits [n*STREAM_WIDTH +: STREAM_WIDTH]
ib_valid_i  in  CHANNELS  per-channel valid
ib_ready_o  out  CHANNELS  per-channel ready
arb_data_o  out  STREAM_WIDTH  arbitrated message
arb_dir_o  out  $clog2(CHANNELS)  source channel index of arb_data_o
arb_valid_o  out  1  output valid
arb_ready_i  in  1  output ready
level_o  out  CHANNELS*($clog2(FIFO_DEPTH)+1)  per-channel FIFO occupancy, packed
idle_o  out  1  high when every FIFO is empty and arb_valid_o is low

Behaviour:
- Interface: one clock (clk_i). Reset is synchronous and active-high (rst_i); all state changes on the rising edge of clk_i.
- Reset values:
  - All FIFOs empty and level_o = 0.
  - arb_valid_o = 0, arb_data_o = 0, arb_dir_o = 0.
  - idle_o = 1.
  - Round-robin last-grant pointer = CHANNELS-1, so channel 0 has first priority.
  - ib_ready_o = 0 in every cycle where rst_i is high (combinational gate).
- Reset mid-operation: all buffered and presented data is discarded with no drain. The first cycle after rst_i falls behaves exactly as the first cycle after a cold reset.
- Inbound handshake:
  - ib_ready_o[n] = !rst_i && (registered count[n] != FIFO_DEPTH).
  - A push occurs on a cycle where ib_valid_i[n] && ib_ready_o[n].
  - A full FIFO holds ready low even if it pops in the same cycle. There is no full-FIFO push-through.
- Output stage:
  - arb_data_o, arb_dir_o and arb_valid_o come from a single output register.
  - load_en = !arb_valid_o || arb_ready_i.
  - On load_en, the selected non-empty FIFO pops into the register and arb_valid_o goes to 1. If no FIFO is non-empty, arb_valid_o goes to 0.
  - While arb_valid_o && !arb_ready_i, arb_data_o and arb_dir_o hold stable.
- Latency and throughput:
  - A message accepted in cycle c is visible on arb_valid_o in cycle c+2 at the earliest. A FIFO cannot push and pop the same entry in one cycle.
  - Sustained throughput is 1 message per cycle while arb_ready_i is held high.
  - The same FIFO may push and pop in one cycle when not full; its count is then unchanged.
- Round-robin (ARB_MODE=0):
  - The grant goes to the first non-empty channel searching upward from last_grant+1, modulo CHANNELS.
  - last_grant updates only when a pop occurs.
- Fixed priority (ARB_MODE=1): the grant goes to the lowest-index non-empty channel; there is no pointer.
- FIFO pointers:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy is a separate count, $clog2(FIFO_DEPTH)+1 bits wide, so that full and empty are unambiguous.
- Ordering: message order is preserved within a channel. There is no ordering guarantee across channels.
- idle_o is combinational from the registered state (FIFO counts and arb_valid_o).

Decomposition:
- Package nx_arb_pkg:
  - arb_mode_t enum with ARB_ROUND_ROBIN = 0 and ARB_FIXED_PRIORITY = 1.
  - Width helper localparams.
- Sub-module nx_stream_fifo (STREAM_WIDTH, FIFO_DEPTH):
  - Ports: push/data/full, pop/head/empty, level.
  - Instantiated CHANNELS times in a generate loop.
  - Arbitration and the output register stay in the top module.

Test Plan:
- Reset, then all ib_valid_i low: idle_o = 1, ib_ready_o = all ones, arb_valid_o = 0. Then one push of 0xA5A5_0001 on channel 2 in cycle c: arb_valid_o = 1 in cycle c+2 with arb_data_o = 0xA5A5_0001, arb_dir_o = 2.
- Round-robin, all four channels continuously valid, arb_ready_i = 1: arb_dir_o sequence is 0,1,2,3,0,1… with one grant per cycle and no channel starved.
- Fixed priority, channels 0 and 3 continuously valid: only channel 0 is granted. Channel 3's FIFO fills to level 2, then ib_ready_o[3] = 0. When channel 0's valid drops, channel 3 drains.
- Back-pressure: arb_ready_i = 0 for 10 cycles while channel 1 pushes 1, 2, 3. The output holds 1 stable, the FIFO reaches full, and ib_ready_o[1] = 0. On release, the outputs are 1, 2, 3 in order.
- Wrap-around: 9 pushes and pops through a FIFO_DEPTH=2 FIFO, alternating full and empty. All 9 values are received in order and level_o returns to 0.
- Reset asserted while 3 FIFOs hold data and arb_valid_o = 1: the next cycle has arb_valid_o = 0, level_o = 0 and idle_o = 1. No stale message ever appears afterwards.
